// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus-level constants for the I2C master
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ACK_ADDR,
    WR_DATA,
    ACK_DATA,
    RD_DATA,
    MACK,
    STOP
  } i2c_state_e;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;

endpackage

// File: rtl/i2c_qtick_gen.sv
// rtl/i2c_qtick_gen.sv - divides CLK into SCL quarter ticks with a 2-bit quarter index
module i2c_qtick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic       hold,
  output logic       qtick,
  output logic [1:0] quarter
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic [1:0] quarter_q, quarter_d;

  always_comb begin
    cnt_d     = cnt_q;
    quarter_d = quarter_q;
    qtick     = 1'b0;
    if (!en) begin
      cnt_d     = '0;
      quarter_d = '0;
    end else if (!hold) begin
      if (cnt_q == LAST) begin
        qtick     = 1'b1;
        cnt_d     = '0;
        quarter_d = quarter_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      quarter_q <= quarter_d;
    end
  end

  assign quarter = quarter_q;

endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-byte I2C master (write or read, 7-bit address)
// Slave clock stretching is honoured only when I2CM_CLK_STRETCH_EN is defined.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       nack_err,
  output logic       busy,
  output logic       SCL,
  input  logic       SCL_I,
  output logic       SDA_O,
  output logic       SDA_OE,
  input  logic       SDA_I
);

  i2c_state_e state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] addr_byte_q, addr_byte_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rx_q, rx_d;
  logic       smp_q, smp_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       nack_q, nack_d;
  logic       ready_q, ready_d;

  logic       qtick, hold, en;
  logic [1:0] quarter;
  logic       scl_o, sda_o, sda_oe;
  logic       bit_end, sample;

  assign en = (state_q != IDLE);

`ifdef I2CM_CLK_STRETCH_EN
  // Freeze the quarter counter while we release SCL but a slave still holds it low.
  assign hold = scl_o && !SCL_I;
`else
  logic unused_scl_i;
  assign unused_scl_i = SCL_I;
  assign hold = 1'b0;
`endif

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .CLK     (CLK),
    .RST     (RST),
    .en      (en),
    .hold    (hold),
    .qtick   (qtick),
    .quarter (quarter)
  );

  assign bit_end = qtick && (quarter == 2'd3);
  assign sample  = qtick && (quarter == 2'd2);

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    addr_byte_d = addr_byte_q;
    wdata_d     = wdata_q;
    rx_d        = rx_q;
    smp_d       = sample ? SDA_I : smp_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    nack_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          addr_byte_d = {cmd_addr, cmd_rw};
          wdata_d     = cmd_wdata;
          state_d     = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = ADDR;
          bit_d   = 3'd7;
        end
      end
      ADDR: begin
        if (bit_end) begin
          if (bit_q == 3'd0) state_d = ACK_ADDR;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      ACK_ADDR: begin
        if (bit_end) begin
          bit_d = 3'd7;
          if (smp_q == I2C_NACK) begin
            nack_d  = 1'b1;
            state_d = STOP;
            bit_d   = 3'd1;
          end else if (addr_byte_q[0] == I2C_READ) begin
            state_d = RD_DATA;
          end else begin
            state_d = WR_DATA;
          end
        end
      end
      WR_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd0) state_d = ACK_DATA;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      ACK_DATA: begin
        if (bit_end) begin
          nack_d  = (smp_q == I2C_NACK);
          state_d = STOP;
          bit_d   = 3'd1;
        end
      end
      RD_DATA: begin
        if (sample) rx_d = {rx_q[6:0], SDA_I};
        if (bit_end) begin
          if (bit_q == 3'd0) state_d = MACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      MACK: begin
        if (bit_end) begin
          rd_data_d  = rx_q;
          rd_valid_d = 1'b1;
          state_d    = STOP;
          bit_d      = 3'd1;
        end
      end
      STOP: begin
        // Second STOP bit is bus-free time so back-to-back commands keep a gap.
        if (bit_end) begin
          if (bit_q == 3'd0) state_d = IDLE;
          else               bit_d   = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_comb begin
    scl_o  = 1'b1;
    sda_oe = 1'b0;
    sda_o  = 1'b1;
    case (state_q)
      START: begin
        scl_o  = !quarter[1];
        sda_oe = 1'b1;
        sda_o  = 1'b0;
      end
      ADDR: begin
        scl_o  = quarter[1];
        sda_oe = 1'b1;
        sda_o  = addr_byte_q[bit_q];
      end
      WR_DATA: begin
        scl_o  = quarter[1];
        sda_oe = 1'b1;
        sda_o  = wdata_q[bit_q];
      end
      ACK_ADDR, ACK_DATA, RD_DATA, MACK: scl_o = quarter[1];
      STOP: begin
        if (bit_q == 3'd1) begin
          scl_o = (quarter != 2'd0);
          if (!quarter[1]) begin
            sda_oe = 1'b1;
            sda_o  = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      bit_q       <= '0;
      addr_byte_q <= '0;
      wdata_q     <= '0;
      rx_q        <= '0;
      smp_q       <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      nack_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      addr_byte_q <= addr_byte_d;
      wdata_q     <= wdata_d;
      rx_q        <= rx_d;
      smp_q       <= smp_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      nack_q      <= nack_d;
      ready_q     <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = en;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign nack_err  = nack_q;
  assign SCL       = scl_o;
  assign SDA_O     = sda_o;
  assign SDA_OE    = sda_oe;

endmodule
